// File: rtl/ovl_win_check_sched.sv
// Shared window checker: round-robin arbitrates one requester at a time, snapshots its
// expression and flags value changes, X/Z or timeout until the owner's window end.
module ovl_win_check_sched #(
  parameter int unsigned width      = 8,
  parameter int unsigned num_req    = 4,
  parameter int unsigned max_window = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [num_req-1:0]       req_start,
  input  logic [num_req-1:0]       req_end,
  input  logic [num_req*width-1:0] req_expr,
  output logic [num_req-1:0]       grant,
  output logic                     busy,
  output logic                     fire,
  output logic [1:0]               fire_type,
  output logic [2:0]               fire_id,
  output logic                     done,
  output logic                     dropped
);

  typedef enum logic [1:0] {StIdle, StOpen, StReport} state_e;

  state_e           state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       owner_q, owner_d;
  logic [width-1:0] snapshot_q, snapshot_d;
  logic [7:0]       count_q, count_d;
  logic             fire_q, fire_d;
  logic [1:0]       fire_type_q, fire_type_d;
  logic [2:0]       fire_id_q, fire_id_d;
  logic             done_q, done_d;
  logic             dropped_q, dropped_d;

  logic               arb_valid;
  logic [2:0]         arb_idx;
  int unsigned        arb_scan;
  logic [num_req-1:0] arb_mask;
  logic [num_req-1:0] owner_mask;
  logic [width-1:0]   arb_expr;
  logic [width-1:0]   owner_expr;
  logic [2:0]         next_ptr;
  logic               owner_xz;

  // Lowest requesting index at or above rr_ptr, wrapping around.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = rr_ptr_q;
    arb_scan  = 0;
    for (int unsigned k = 0; k < num_req; k++) begin
      arb_scan = (32'(rr_ptr_q) + k) % num_req;
      if (!arb_valid && req_start[arb_scan]) begin
        arb_valid = 1'b1;
        arb_idx   = 3'(arb_scan);
      end
    end
  end

  assign arb_mask   = {{(num_req-1){1'b0}}, 1'b1} << arb_idx;
  assign owner_mask = {{(num_req-1){1'b0}}, 1'b1} << owner_q;
  assign arb_expr   = req_expr[32'(arb_idx)*width +: width];
  assign owner_expr = req_expr[32'(owner_q)*width +: width];
  assign next_ptr   = (owner_q == 3'(num_req-1)) ? 3'd0 : owner_q + 3'd1;
  assign owner_xz   = $isunknown(owner_expr);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    snapshot_d  = snapshot_q;
    count_d     = count_q;
    fire_d      = 1'b0;
    fire_type_d = 2'b00;
    fire_id_d   = 3'd0;
    done_d      = 1'b0;
    dropped_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d    = StOpen;
          owner_d    = arb_idx;
          snapshot_d = arb_expr;
          count_d    = 8'd0;
          dropped_d  = |(req_start & ~arb_mask);
        end
      end
      StOpen: begin
        dropped_d = |(req_start & ~owner_mask);
        count_d   = count_q + 8'd1;
        // Priority: X/Z, then value change, then clean end, then timeout.
        if (owner_xz) begin
          state_d     = StReport;
          fire_d      = 1'b1;
          fire_type_d = 2'b11;
          fire_id_d   = owner_q;
          rr_ptr_d    = next_ptr;
        end else if (owner_expr != snapshot_q) begin
          state_d     = StReport;
          fire_d      = 1'b1;
          fire_type_d = 2'b01;
          fire_id_d   = owner_q;
          rr_ptr_d    = next_ptr;
        end else if (req_end[owner_q]) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          rr_ptr_d = next_ptr;
        end else if (count_q == 8'(max_window-1)) begin
          state_d     = StReport;
          fire_d      = 1'b1;
          fire_type_d = 2'b10;
          fire_id_d   = owner_q;
          rr_ptr_d    = next_ptr;
        end
      end
      StReport: begin
        dropped_d = |req_start;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 3'd0;
      owner_q     <= 3'd0;
      snapshot_q  <= '0;
      count_q     <= 8'd0;
      fire_q      <= 1'b0;
      fire_type_q <= 2'b00;
      fire_id_q   <= 3'd0;
      done_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      snapshot_q  <= snapshot_d;
      count_q     <= count_d;
      fire_q      <= fire_d;
      fire_type_q <= fire_type_d;
      fire_id_q   <= fire_id_d;
      done_q      <= done_d;
      dropped_q   <= dropped_d;
    end
  end

  assign busy      = (state_q == StOpen);
  assign grant     = busy ? owner_mask : '0;
  assign fire      = fire_q;
  assign fire_type = fire_type_q;
  assign fire_id   = fire_id_q;
  assign done      = done_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_ovl_win_check_sched.sv
// Directed and randomized checks of ovl_win_check_sched against a per-window outcome model.
module tb_ovl_win_check_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_start;
  logic [3:0]  req_end;
  logic [31:0] req_expr;
  logic [3:0]  grant;
  logic        busy, fire, done, dropped;
  logic [1:0]  fire_type;
  logic [2:0]  fire_id;

  int total = 0;
  int bad   = 0;

  ovl_win_check_sched #(.width(8), .num_req(4), .max_window(16)) dut (
    .clk(clk), .reset(reset), .req_start(req_start), .req_end(req_end), .req_expr(req_expr),
    .grant(grant), .busy(busy), .fire(fire), .fire_type(fire_type), .fire_id(fire_id),
    .done(done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_expr(input int i, input logic [7:0] v);
    req_expr[i*8 +: 8] = v;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_start = '0;
    req_end = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_expr = '0;
    req_start = '0;
    req_end = '0;
    reset = 1'b1;
    #1;
    total++;
    if ({grant, busy, fire, fire_type, fire_id, done, dropped} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", {grant, busy, fire, fire_type, fire_id, done, dropped});
    end
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    total++;
    if ({grant, busy, fire, done, dropped} !== 8'd0) begin
      bad++;
      $display("FAIL reset_idle: got %b want 0", {grant, busy, fire, done, dropped});
    end
  endtask

  task automatic test_clean_window();
    set_expr(1, 8'h5A);
    req_start = 4'b0010;
    cyc();
    req_start = '0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (grant !== 4'b0010 || busy !== 1'b1 || fire !== 1'b0) begin
        bad++;
        $display("FAIL clean_open: got grant=%b busy=%b fire=%b want 0010 1 0", grant, busy, fire);
      end
      if (i == 4) req_end = 4'b0010;
      cyc();
    end
    req_end = '0;
    total++;
    if (done !== 1'b1 || fire !== 1'b0 || grant !== 4'b0000) begin
      bad++;
      $display("FAIL clean_done: got done=%b fire=%b grant=%b want 1 0 0000", done, fire, grant);
    end
    // rr_ptr should now be 2: requester 2 beats requester 0.
    req_start = 4'b0101;
    cyc();
    total++;
    if (grant !== 4'b0100 || done !== 1'b0 || dropped !== 1'b1) begin
      bad++;
      $display("FAIL clean_rr: got grant=%b done=%b dropped=%b want 0100 0 1", grant, done, dropped);
    end
    req_start = '0;
    req_end = 4'b0100;
    cyc();
    req_end = '0;
    cyc();
  endtask

  task automatic test_mismatch();
    set_expr(0, 8'h11);
    req_start = 4'b0001;
    cyc();
    req_start = '0;
    cyc();
    cyc();
    set_expr(0, 8'h12);
    cyc();
    total++;
    if (fire !== 1'b1 || fire_type !== 2'b01 || fire_id !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mismatch_fire: got fire=%b type=%b id=%0d busy=%b want 1 01 0 0",
               fire, fire_type, fire_id, busy);
    end
    cyc();
    total++;
    if (fire !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000) begin
      bad++;
      $display("FAIL mismatch_idle: got fire=%b busy=%b grant=%b want 0 0 0000", fire, busy, grant);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    set_expr(2, 8'h3C);
    req_start = 4'b0100;
    cyc();
    req_start = '0;
    for (int k = 1; k <= 16; k++) begin
      if (busy !== 1'b1 || fire !== 1'b0) early++;
      cyc();
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL timeout_open: got %0d bad OPEN cycles want 0", early);
    end
    total++;
    if (fire !== 1'b1 || fire_type !== 2'b10 || fire_id !== 3'd2) begin
      bad++;
      $display("FAIL timeout_fire: got fire=%b type=%b id=%0d want 1 10 2", fire, fire_type, fire_id);
    end
    cyc();
  endtask

  task automatic test_arbitration();
    apply_reset();
    req_start = 4'b1111;
    cyc();
    req_start = '0;
    total++;
    if (grant !== 4'b0001 || dropped !== 1'b1) begin
      bad++;
      $display("FAIL arb_first: got grant=%b dropped=%b want 0001 1", grant, dropped);
    end
    cyc();
    total++;
    if (dropped !== 1'b0) begin
      bad++;
      $display("FAIL arb_drop_pulse: got %b want 0", dropped);
    end
    req_end = 4'b0001;
    cyc();
    req_end = '0;
    req_start = 4'b1111;
    cyc();
    req_start = '0;
    total++;
    if (grant !== 4'b0010 || dropped !== 1'b1) begin
      bad++;
      $display("FAIL arb_second: got grant=%b dropped=%b want 0010 1", grant, dropped);
    end
    req_end = 4'b0010;
    cyc();
    req_end = '0;
    cyc();
  endtask

  task automatic test_end_vs_change();
    set_expr(3, 8'h33);
    req_start = 4'b1000;
    cyc();
    req_start = '0;
    set_expr(3, 8'h34);
    req_end = 4'b1000;
    cyc();
    req_end = '0;
    total++;
    if (fire !== 1'b1 || fire_type !== 2'b01 || fire_id !== 3'd3 || done !== 1'b0) begin
      bad++;
      $display("FAIL endchg_fire: got fire=%b type=%b id=%0d done=%b want 1 01 3 0",
               fire, fire_type, fire_id, done);
    end
    // A start arriving during the report cycle is dropped, not queued.
    req_start = 4'b0001;
    cyc();
    req_start = '0;
    total++;
    if (dropped !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL report_drop: got dropped=%b done=%b busy=%b want 1 0 0", dropped, done, busy);
    end
    cyc();
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL report_noqueue: got grant=%b busy=%b want 0000 0", grant, busy);
    end
  endtask

  task automatic test_xz();
    logic [7:0] seen;
    logic [1:0] exp_type;
    set_expr(0, 8'hFF);
    req_start = 4'b0001;
    cyc();
    req_start = '0;
    req_expr[0] = 1'bz;
    seen = req_expr[7:0];
    if ($isunknown(seen)) exp_type = 2'b11;
    else if (seen != 8'hFF) exp_type = 2'b01;
    else exp_type = 2'b00;
    cyc();
    total++;
    if (fire !== (exp_type != 2'b00) || (exp_type != 2'b00 && fire_type !== exp_type)) begin
      bad++;
      $display("FAIL xz_fire: got fire=%b type=%b want type %b", fire, fire_type, exp_type);
    end
    set_expr(0, 8'hFF);
    req_end = 4'b0001;
    cyc();
    req_end = '0;
    cyc();
  endtask

  task automatic test_reset_mid_window();
    int late = 0;
    set_expr(1, 8'hA5);
    req_start = 4'b0010;
    cyc();
    req_start = '0;
    cyc();
    cyc();
    set_expr(1, 8'hA6);
    req_end = 4'b0010;
    reset = 1'b1;
    #1;
    total++;
    if ({grant, busy, fire, fire_type, fire_id, done, dropped} !== 13'd0) begin
      bad++;
      $display("FAIL midreset_async: got %b want 0", {grant, busy, fire, fire_type, fire_id, done, dropped});
    end
    cyc();
    reset = 1'b0;
    req_end = '0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (fire !== 1'b0 || done !== 1'b0 || busy !== 1'b0) late++;
    end
    total++;
    if (late != 0) begin
      bad++;
      $display("FAIL midreset_quiet: got %0d pulses want 0", late);
    end
    req_start = 4'b1111;
    cyc();
    req_start = '0;
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL midreset_grant: got %b want 0001", grant);
    end
    req_end = 4'b0001;
    cyc();
    req_end = '0;
    cyc();
  endtask

  // Outcome per window: first of value change, owner end, or 16th OPEN cycle timeout.
  task automatic test_random(input int n);
    int rr = 0;
    apply_reset();
    for (int t = 0; t < n; t++) begin
      logic [3:0] mask;
      logic [7:0] snap;
      int owner, chg_at, end_at, last, kind, noise, j;
      logic exp_drop;
      mask = 4'($urandom_range(1, 15));
      owner = -1;
      for (int k = 0; k < 4; k++)
        if (owner < 0 && mask[(rr + k) % 4]) owner = (rr + k) % 4;
      for (int i = 0; i < 4; i++) set_expr(i, 8'($urandom));
      snap = req_expr[owner*8 +: 8];
      chg_at = $urandom_range(1, 24);
      end_at = $urandom_range(1, 24);
      last = 0;
      kind = 0;
      for (int k = 1; k <= 16; k++) begin
        if (last == 0) begin
          if (k >= chg_at) begin last = k; kind = 1; end
          else if (k == end_at) begin last = k; kind = 3; end
          else if (k == 16) begin last = k; kind = 2; end
        end
      end
      req_start = mask;
      req_end = '0;
      cyc();
      exp_drop = (mask & ~(4'b0001 << owner)) != 4'b0000;
      for (int k = 1; k <= last; k++) begin
        total++;
        if (grant !== (4'b0001 << owner) || busy !== 1'b1 || fire !== 1'b0 || done !== 1'b0 ||
            dropped !== exp_drop) begin
          bad++;
          $display("FAIL rand_open t=%0d k=%0d: got g=%b b=%b f=%b d=%b dr=%b want g=%b dr=%b",
                   t, k, grant, busy, fire, done, dropped, 4'b0001 << owner, exp_drop);
        end
        noise = $urandom_range(0, 1);
        j = (owner + $urandom_range(1, 3)) % 4;
        req_start = (noise != 0 ? 4'b0001 << j : 4'b0000) |
                    ($urandom_range(0, 1) != 0 ? 4'b0001 << owner : 4'b0000);
        req_end = 4'($urandom) & ~(4'b0001 << owner);
        if (k == end_at) req_end[owner] = 1'b1;
        for (int i = 0; i < 4; i++) if (i != owner) set_expr(i, 8'($urandom));
        set_expr(owner, (k >= chg_at) ? snap ^ (8'd1 << $urandom_range(0, 7)) : snap);
        exp_drop = (noise != 0);
        cyc();
      end
      total++;
      if (busy !== 1'b0 || grant !== 4'b0000 || fire !== (kind != 3) || done !== (kind == 3) ||
          dropped !== exp_drop ||
          (kind == 1 && (fire_type !== 2'b01 || fire_id !== 3'(owner))) ||
          (kind == 2 && (fire_type !== 2'b10 || fire_id !== 3'(owner)))) begin
        bad++;
        $display("FAIL rand_close t=%0d: got f=%b ty=%b id=%0d d=%b dr=%b want kind=%0d id=%0d dr=%b",
                 t, fire, fire_type, fire_id, done, dropped, kind, owner, exp_drop);
      end
      req_start = '0;
      req_end = '0;
      cyc();
      total++;
      if (fire !== 1'b0 || done !== 1'b0 || dropped !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rand_settle t=%0d: got f=%b d=%b dr=%b b=%b want 0", t, fire, done, dropped, busy);
      end
      rr = (owner + 1) % 4;
    end
  endtask

  initial begin
    test_reset();
    test_clean_window();
    test_mismatch();
    test_timeout();
    test_arbitration();
    test_end_vs_change();
    test_xz();
    test_reset_mid_window();
    test_random(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
